vga_timing_receiver: RTL and testbench
======================================

Name: vga_timing_receiver

Overview:
Sink-side counterpart to the VGA timing generator. It accepts hsync/vsync/video_active/RGB from a VGA source and measures the line and frame timing. It recovers per-pixel coordinates, declares lock once timing is stable, and produces a per-frame RGB checksum. It is used in loopback self-test and as the front end of capture/scaler paths.

Parameters:
SYNC_ACTIVE_LOW, 1, 1: hsync/vsync assert low; 0: assert high
LOCK_FRAMES, 2, consecutive identical frame measurements required to assert locked (1..15)
H_TIMEOUT, 2047, clocks without an hsync assertion before loss of signal

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
de_in  in  1  video active
rgb_r_in/rgb_g_in/rgb_b_in  in  8 each  pixel colour
pixel_valid  out  1  registered de_in
pixel_x  out  11  active-pixel index within line
pixel_y  out  10  active-line index within frame
rgb_r/rgb_g/rgb_b  out  8 each  registered pixel colour
h_total, h_active, h_sync_w  out  11 each  measured clocks per line / active clocks per line / hsync width in clocks
v_total, v_active, v_sync_w  out  10 each  lines per frame / active lines / vsync width in lines
frame_checksum  out  32  sum of active pixels, latched per frame
frame_done  out  1  1-cycle pulse when measurements and checksum update
locked  out  1  timing stable
timing_err  out  1  1-cycle pulse on loss of lock or timeout

Behaviour:
- Reset (async, rst=1): all outputs 0; state SEARCH; all internal counters 0.
- Sync inputs are registered once. Edges are detected on the registered copy. "Assertion edge" means the transition to the active level per SYNC_ACTIVE_LOW.
- Line counters:
  - hcnt counts clocks since the last hsync assertion edge.
  - At each hsync assertion edge, the line is closed: line_total = hcnt+1, line_active = de-high clocks in the line, line_syncw = width of the previous hsync pulse.
  - Then hcnt and the de count clear to 0.
- Frame counters:
  - lcnt counts hsync assertion edges since the last vsync assertion edge.
  - vact counts lines with at least one de-high clock.
  - vsw counts hsync assertion edges while vsync is asserted.
- Counters saturate at their maximum and never wrap.
- Pixel path:
  - 1-cycle latency. pixel_valid, rgb_* and pixel_x/pixel_y reflect the inputs of the previous cycle.
  - pixel_x = de-high clocks already seen in the current line, so the first active pixel is 0.
  - pixel_y = active lines completed since the vsync edge.
  - When de is low, pixel_x/pixel_y hold their last value and rgb_* = 0.
- Checksum: accumulate {r,g,b} as a 24-bit value, zero-extended, mod 2^32, on every de-high clock.
- Vsync assertion edge: latch h_total/h_active/h_sync_w from the last closed line, plus v_total=lcnt, v_active=vact, v_sync_w=vsw, and frame_checksum. Pulse frame_done. Clear the frame counters and the accumulator.
- A coincident hsync edge is counted before the frame closes.
- State machine:
  - SEARCH: wait for the first vsync assertion edge (no latch, no frame_done) -> MEASURE.
  - MEASURE: at each vsync edge, compare the new 6-field set with the previous latched set. Equal -> match_cnt++. Differ -> match_cnt=0. The first latched set has nothing to compare against, so match_cnt stays 0. When match_cnt==LOCK_FRAMES -> LOCKED, locked=1.
  - LOCKED: any field mismatch at a vsync edge -> MEASURE, match_cnt=0, locked=0, timing_err pulse.
  - Any state: hcnt reaching H_TIMEOUT -> SEARCH, locked=0, timing_err pulses once if the previous state was LOCKED; outputs hold their last values.
- Reset mid-frame: everything returns to SEARCH. The partial frame is discarded.

Test Plan:
1. 640x480 generator timing (800/640/96, 525/480/2, active-low syncs) for 5 frames -> h_total=800, h_active=640, h_sync_w=96, v_total=525, v_active=480, v_sync_w=2; locked rises at the 4th vsync edge; no timing_err.
2. Constant colour r=0x01, g=b=0 -> frame_checksum=0xB0000000 on every frame_done; pixel_x spans 0..639 and pixel_y spans 0..479 on pixel_valid.
3. While locked, one frame with h_total=801 -> timing_err pulse and locked=0 at that vsync edge; relock after LOCK_FRAMES further good frames.
4. Hold hsync deasserted for 2047 clocks while locked -> timing_err once, state SEARCH, locked=0; the next vsync edge produces no frame_done.
5. SYNC_ACTIVE_LOW=0 with inverted syncs -> same measurements as scenario 1.
6. Assert rst mid-frame 200 -> all outputs 0; after release, the first frame_done occurs at the second vsync edge.

Source files
------------

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: registers the incoming syncs, measures line and frame
// timing, recovers active-pixel coordinates, accumulates a per-frame RGB
// checksum and tracks whether the measured timing is stable (locked).
module vga_timing_receiver #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2,
  parameter int H_TIMEOUT       = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic [7:0]  rgb_r_in,
  input  logic [7:0]  rgb_g_in,
  input  logic [7:0]  rgb_b_in,
  output logic        pixel_valid,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic [10:0] h_total,
  output logic [10:0] h_active,
  output logic [10:0] h_sync_w,
  output logic [9:0]  v_total,
  output logic [9:0]  v_active,
  output logic [9:0]  v_sync_w,
  output logic [31:0] frame_checksum,
  output logic        frame_done,
  output logic        locked,
  output logic        timing_err
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  localparam logic [3:0]  LOCK_CNT   = 4'(LOCK_FRAMES);
  localparam logic [10:0] TIMEOUT_M1 = 11'(H_TIMEOUT - 1);

  // Saturating increments: counters stick at all-ones instead of wrapping.
  function automatic logic [10:0] inc11(input logic [10:0] v, input logic en);
    return (en && (v != '1)) ? v + 11'd1 : v;
  endfunction

  function automatic logic [9:0] inc10(input logic [9:0] v, input logic en);
    return (en && (v != '1)) ? v + 10'd1 : v;
  endfunction

  // Sync stage (active-level copies) and their one-cycle-delayed versions.
  logic        hs_a_q, hs_a_d, hs_p_q, hs_p_d;
  logic        vs_a_q, vs_a_d, vs_p_q, vs_p_d;
  // Line measurement.
  logic [10:0] hcnt_q, hcnt_d, dcnt_q, dcnt_d, dcnt_base;
  logic [10:0] hsw_q, hsw_d, hpw_q, hpw_d;
  logic [10:0] ln_tot_q, ln_tot_d, ln_act_q, ln_act_d, ln_sync_q, ln_sync_d;
  // Frame measurement.
  logic [9:0]  lcnt_q, lcnt_d, vact_q, vact_d, vsw_q, vsw_d;
  logic [9:0]  lcnt_inc, vact_inc, vsw_inc;
  logic [31:0] acc_q, acc_d, acc_inc;
  // Pixel path.
  logic        pix_vld_q, pix_vld_d;
  logic [10:0] pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  // Latched frame results and lock tracking.
  logic [10:0] h_total_q, h_total_d, h_active_q, h_active_d, h_sync_w_q, h_sync_w_d;
  logic [9:0]  v_total_q, v_total_d, v_active_q, v_active_d, v_sync_w_q, v_sync_w_d;
  logic [31:0] csum_q, csum_d;
  logic        fdone_q, fdone_d, locked_q, locked_d, terr_q, terr_d;
  logic        have_prev_q, have_prev_d;
  logic [3:0]  match_q, match_d, match_inc;
  state_t      state_q, state_d;

  logic hs_edge, hs_fall, vs_edge, timeout, same;

  assign hs_edge = hs_a_q & ~hs_p_q;
  assign hs_fall = ~hs_a_q & hs_p_q;
  assign vs_edge = vs_a_q & ~vs_p_q;
  // Fires once per silent stretch: the count only passes this value once.
  assign timeout = !hs_edge && (hcnt_q == TIMEOUT_M1);

  // Line/frame counters; a coincident hsync edge is folded in before the frame closes.
  always_comb begin
    hs_a_d    = hsync_in ^ SYNC_ACTIVE_LOW;
    vs_a_d    = vsync_in ^ SYNC_ACTIVE_LOW;
    hs_p_d    = hs_a_q;
    vs_p_d    = vs_a_q;
    hcnt_d    = hs_edge ? 11'd0 : inc11(hcnt_q, 1'b1);
    dcnt_base = hs_edge ? 11'd0 : dcnt_q;
    dcnt_d    = inc11(dcnt_base, de_in);
    hsw_d     = hs_edge ? 11'd1 : inc11(hsw_q, hs_a_q);
    hpw_d     = hs_fall ? hsw_q : hpw_q;
    ln_tot_d  = hs_edge ? inc11(hcnt_q, 1'b1) : ln_tot_q;
    ln_sync_d = hs_edge ? hpw_q : ln_sync_q;
    // Blanking lines carry no de, so keep the length of the last line that did.
    ln_act_d  = (hs_edge && (dcnt_q != '0)) ? dcnt_q : ln_act_q;
    lcnt_inc  = inc10(lcnt_q, hs_edge);
    vact_inc  = inc10(vact_q, hs_edge && (dcnt_q != '0));
    vsw_inc   = inc10(vsw_q, hs_edge && vs_a_q);
    acc_inc   = acc_q + (de_in ? {8'h00, rgb_r_in, rgb_g_in, rgb_b_in} : 32'd0);
    lcnt_d    = vs_edge ? 10'd0 : lcnt_inc;
    vact_d    = vs_edge ? 10'd0 : vact_inc;
    vsw_d     = vs_edge ? 10'd0 : vsw_inc;
    acc_d     = vs_edge ? 32'd0 : acc_inc;
  end

  // Pixel path: one-cycle registered copy with recovered coordinates.
  always_comb begin
    pix_vld_d = de_in;
    r_d       = de_in ? rgb_r_in : 8'd0;
    g_d       = de_in ? rgb_g_in : 8'd0;
    b_d       = de_in ? rgb_b_in : 8'd0;
    pix_x_d   = de_in ? dcnt_base : pix_x_q;
    pix_y_d   = de_in ? vact_d : pix_y_q;
  end

  assign same = (ln_tot_d == h_total_q) && (ln_act_d == h_active_q) &&
                (ln_sync_d == h_sync_w_q) && (lcnt_inc == v_total_q) &&
                (vact_inc == v_active_q) && (vsw_inc == v_sync_w_q);
  assign match_inc = (match_q == 4'hF) ? match_q : match_q + 4'd1;

  // Lock FSM next state, frame latching and status pulses.
  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    fdone_d     = 1'b0;
    terr_d      = 1'b0;
    h_total_d   = h_total_q;
    h_active_d  = h_active_q;
    h_sync_w_d  = h_sync_w_q;
    v_total_d   = v_total_q;
    v_active_d  = v_active_q;
    v_sync_w_d  = v_sync_w_q;
    csum_d      = csum_q;
    if (timeout) begin
      state_d     = ST_SEARCH;
      match_d     = 4'd0;
      have_prev_d = 1'b0;
      locked_d    = 1'b0;
      terr_d      = (state_q == ST_LOCKED);
    end else if (vs_edge) begin
      if (state_q == ST_SEARCH) begin
        // First edge only aligns us to a frame start; nothing is latched.
        state_d = ST_MEASURE;
      end else begin
        h_total_d   = ln_tot_d;
        h_active_d  = ln_act_d;
        h_sync_w_d  = ln_sync_d;
        v_total_d   = lcnt_inc;
        v_active_d  = vact_inc;
        v_sync_w_d  = vsw_inc;
        csum_d      = acc_inc;
        fdone_d     = 1'b1;
        have_prev_d = 1'b1;
        if (state_q == ST_MEASURE) begin
          if (have_prev_q && same) begin
            match_d = match_inc;
            if (match_inc == LOCK_CNT) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d = 4'd0;
          end
        end else if (!same) begin
          state_d  = ST_MEASURE;
          match_d  = 4'd0;
          locked_d = 1'b0;
          terr_d   = 1'b1;
        end
      end
    end
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_a_q <= 1'b0; hs_p_q <= 1'b0; vs_a_q <= 1'b0; vs_p_q <= 1'b0;
      hcnt_q <= '0; dcnt_q <= '0; hsw_q <= '0; hpw_q <= '0;
      ln_tot_q <= '0; ln_act_q <= '0; ln_sync_q <= '0;
      lcnt_q <= '0; vact_q <= '0; vsw_q <= '0; acc_q <= '0;
      pix_vld_q <= 1'b0; pix_x_q <= '0; pix_y_q <= '0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      h_total_q <= '0; h_active_q <= '0; h_sync_w_q <= '0;
      v_total_q <= '0; v_active_q <= '0; v_sync_w_q <= '0;
      csum_q <= '0; fdone_q <= 1'b0; locked_q <= 1'b0; terr_q <= 1'b0;
      have_prev_q <= 1'b0; match_q <= '0; state_q <= ST_SEARCH;
    end else begin
      hs_a_q <= hs_a_d; hs_p_q <= hs_p_d; vs_a_q <= vs_a_d; vs_p_q <= vs_p_d;
      hcnt_q <= hcnt_d; dcnt_q <= dcnt_d; hsw_q <= hsw_d; hpw_q <= hpw_d;
      ln_tot_q <= ln_tot_d; ln_act_q <= ln_act_d; ln_sync_q <= ln_sync_d;
      lcnt_q <= lcnt_d; vact_q <= vact_d; vsw_q <= vsw_d; acc_q <= acc_d;
      pix_vld_q <= pix_vld_d; pix_x_q <= pix_x_d; pix_y_q <= pix_y_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      h_total_q <= h_total_d; h_active_q <= h_active_d; h_sync_w_q <= h_sync_w_d;
      v_total_q <= v_total_d; v_active_q <= v_active_d; v_sync_w_q <= v_sync_w_d;
      csum_q <= csum_d; fdone_q <= fdone_d; locked_q <= locked_d; terr_q <= terr_d;
      have_prev_q <= have_prev_d; match_q <= match_d; state_q <= state_d;
    end
  end

  assign pixel_valid    = pix_vld_q;
  assign pixel_x        = pix_x_q;
  assign pixel_y        = pix_y_q;
  assign rgb_r          = r_q;
  assign rgb_g          = g_q;
  assign rgb_b          = b_q;
  assign h_total        = h_total_q;
  assign h_active       = h_active_q;
  assign h_sync_w       = h_sync_w_q;
  assign v_total        = v_total_q;
  assign v_active       = v_active_q;
  assign v_sync_w       = v_sync_w_q;
  assign frame_checksum = csum_q;
  assign frame_done     = fdone_q;
  assign locked         = locked_q;
  assign timing_err     = terr_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver: a scaled-down VGA source drives an
// active-low instance and an active-high instance (inverted syncs) in
// parallel. Expected pixels and frame results go into queues; a monitor
// pops and compares whenever the DUTs present pixel_valid / frame_done.
module tb_vga_timing_receiver;
  localparam int HT = 40, HS = 6, HBP = 6, HA = 24;
  localparam int VT = 20, VS = 2, VBP = 3, VA = 12;

  typedef struct packed {
    logic [10:0] x; logic [9:0] y; logic [23:0] rgb;
  } pix_t;
  typedef struct packed {
    logic [10:0] ht, ha, hw; logic [9:0] vt, va, vw;
    logic [31:0] cs; logic lk, err;
  } frm_t;

  logic clk = 1'b0;
  logic rst, hs, vs, de;
  logic [7:0] r, g, b;
  always #5 clk = ~clk;

  logic pv0, fd0, lk0, te0, pv1, fd1, lk1, te1;
  logic [10:0] px0, px1, ht0, ht1, ha0, ha1, hw0, hw1;
  logic [9:0]  py0, py1, vt0, vt1, va0, va1, vw0, vw1;
  logic [7:0]  ro0, go0, bo0, ro1, go1, bo1;
  logic [31:0] cs0, cs1;

  vga_timing_receiver #(.SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2), .H_TIMEOUT(2047)) dut0 (
    .clk(clk), .rst(rst), .hsync_in(~hs), .vsync_in(~vs), .de_in(de),
    .rgb_r_in(r), .rgb_g_in(g), .rgb_b_in(b),
    .pixel_valid(pv0), .pixel_x(px0), .pixel_y(py0),
    .rgb_r(ro0), .rgb_g(go0), .rgb_b(bo0),
    .h_total(ht0), .h_active(ha0), .h_sync_w(hw0),
    .v_total(vt0), .v_active(va0), .v_sync_w(vw0),
    .frame_checksum(cs0), .frame_done(fd0), .locked(lk0), .timing_err(te0));

  vga_timing_receiver #(.SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2), .H_TIMEOUT(2047)) dut1 (
    .clk(clk), .rst(rst), .hsync_in(hs), .vsync_in(vs), .de_in(de),
    .rgb_r_in(r), .rgb_g_in(g), .rgb_b_in(b),
    .pixel_valid(pv1), .pixel_x(px1), .pixel_y(py1),
    .rgb_r(ro1), .rgb_g(go1), .rgb_b(bo1),
    .h_total(ht1), .h_active(ha1), .h_sync_w(hw1),
    .v_total(vt1), .v_active(va1), .v_sync_w(vw1),
    .frame_checksum(cs1), .frame_done(fd1), .locked(lk1), .timing_err(te1));

  pix_t pq[$];
  frm_t fq[$];
  int   n_checks = 0, n_fail = 0;
  int   err0 = 0, err1 = 0;
  int   prev_ht = HT, prev_ci = 0;
  logic [23:0] cols [4] = '{24'h010000, 24'h0A0B0C, 24'hFFFFFF, 24'h123456};

  frm_t got0, got1;
  pix_t gp0, gp1;
  assign got0 = '{ht0, ha0, hw0, vt0, va0, vw0, cs0, lk0, te0};
  assign got1 = '{ht1, ha1, hw1, vt1, va1, vw1, cs1, lk1, te1};
  assign gp0  = '{px0, py0, {ro0, go0, bo0}};
  assign gp1  = '{px1, py1, {ro1, go1, bo1}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string tag, input frm_t got, input frm_t exp);
    check({tag, " h_total"}, got.ht, exp.ht);
    check({tag, " h_active"}, got.ha, exp.ha);
    check({tag, " h_sync_w"}, got.hw, exp.hw);
    check({tag, " v_total"}, got.vt, exp.vt);
    check({tag, " v_active"}, got.va, exp.va);
    check({tag, " v_sync_w"}, got.vw, exp.vw);
    check({tag, " checksum"}, got.cs, exp.cs);
    check({tag, " locked"}, got.lk, exp.lk);
    check({tag, " timing_err"}, got.err, exp.err);
  endtask

  // Monitor: sample away from the active edge and drain the scoreboards.
  always @(negedge clk) begin
    if (!rst) begin
      if (te0) err0++;
      if (te1) err1++;
      if (pv0 || pv1) begin
        if (pq.size() == 0) check("pixel_valid without expected pixel", {pv1, pv0}, 2'b00);
        else begin
          pix_t p;
          p = pq.pop_front();
          check("pixel_valid both", {pv1, pv0}, 2'b11);
          check("pixel_x lo", px0, p.x);  check("pixel_x hi", px1, p.x);
          check("pixel_y lo", py0, p.y);  check("pixel_y hi", py1, p.y);
          check("rgb lo", gp0.rgb, p.rgb); check("rgb hi", gp1.rgb, p.rgb);
        end
      end else begin
        check("rgb zero when idle", {gp1.rgb, gp0.rgb}, 48'h0);
      end
      if (fd0 || fd1) begin
        if (fq.size() == 0) check("frame_done without expected frame", {fd1, fd0}, 2'b00);
        else begin
          frm_t f;
          f = fq.pop_front();
          check("frame_done both", {fd1, fd0}, 2'b11);
          check_frame("lo", got0, f);
          check_frame("hi", got1, f);
        end
      end
    end
  end

  // One clock of source output; the colour is driven even in blanking so
  // the rgb gating is exercised.
  task automatic drive(input bit h, input bit v, input bit d, input logic [23:0] c,
                       input int x, input int y, input bit rs);
    @(posedge clk); #1;
    rst = rs; hs = h; vs = v; de = d; {r, g, b} = c;
    if (d) pq.push_back('{11'(x), 10'(y), c});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " lo outputs zero"}, 32'(|{pv0, px0, py0, ro0, go0, bo0, ht0, ha0, hw0,
                                          vt0, va0, vw0, cs0, fd0, lk0, te0}), 0);
    check({tag, " hi outputs zero"}, 32'(|{pv1, px1, py1, ro1, go1, bo1, ht1, ha1, hw1,
                                          vt1, va1, vw1, cs1, fd1, lk1, te1}), 0);
  endtask

  // One frame. The vsync edge at its start closes the previous frame, so the
  // expectations given here (done/locked/err) belong to that edge.
  task automatic gen_frame(input int ht, input int ci, input bit exp_done,
                           input bit exp_lk, input bit exp_err, input int rst_line);
    if (exp_done) begin
      frm_t f;
      f.ht = 11'(prev_ht); f.ha = 11'(HA); f.hw = 11'(HS);
      f.vt = 10'(VT); f.va = 10'(VA); f.vw = 10'(VS);
      f.cs = 32'(HA * VA) * {8'h00, cols[prev_ci]};
      f.lk = exp_lk; f.err = exp_err;
      fq.push_back(f);
    end
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < ht; c++) begin
        bit al, ac, rs;
        al = (l >= VS + VBP) && (l < VS + VBP + VA);
        ac = (c >= HS + HBP) && (c < HS + HBP + HA);
        rs = (l == rst_line) && (c >= ht / 2) && (c < ht / 2 + 3);
        drive(c < HS, l < VS, al && ac, cols[ci], c - HS - HBP, l - VS - VBP, rs);
        if (l == 0 && c == 3) begin
          @(negedge clk);
          check("locked after vsync edge", {lk1, lk0}, {exp_lk, exp_lk});
        end
        if (rs && c == ht / 2) begin
          @(negedge clk);
          check_all_zero("mid-frame reset");
        end
      end
    end
    prev_ht = ht;
    prev_ci = ci;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; {r, g, b} = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    // Lock-in: edge 1 aligns, edge 2 latches first set, edges 3/4 match -> locked at 4.
    gen_frame(HT, 0, 0, 0, 0, -1);
    gen_frame(HT, 0, 1, 0, 0, -1);
    gen_frame(HT, 1, 1, 0, 0, -1);
    gen_frame(HT, 1, 1, 1, 0, -1);
    gen_frame(HT, 2, 1, 1, 0, -1);
    // One long-line frame: its close drops lock with timing_err. The next good
    // frame differs from the long one (match 0), then two matches relock.
    gen_frame(HT + 1, 0, 1, 1, 0, -1);
    gen_frame(HT, 0, 1, 0, 1, -1);
    gen_frame(HT, 3, 1, 0, 0, -1);
    gen_frame(HT, 3, 1, 0, 0, -1);
    gen_frame(HT, 0, 1, 1, 0, -1);
    // Silent hsync for longer than the timeout while locked.
    e0 = err0; e1 = err1;
    repeat (2100) drive(1'b0, 1'b0, 1'b0, 24'h0, 0, 0, 1'b0);
    @(negedge clk);
    check("timeout timing_err lo", 32'(err0 - e0), 1);
    check("timeout timing_err hi", 32'(err1 - e1), 1);
    check("timeout locked", {lk1, lk0}, 2'b00);
    // Back in search: first edge silent, second gives frame_done.
    gen_frame(HT, 0, 0, 0, 0, -1);
    gen_frame(HT, 1, 1, 0, 0, -1);
    gen_frame(HT, 1, 1, 0, 0, VS);
    // Reset mid-frame above: partial frame discarded, relock from scratch.
    gen_frame(HT, 2, 0, 0, 0, -1);
    gen_frame(HT, 2, 1, 0, 0, -1);
    gen_frame(HT, 0, 1, 0, 0, -1);
    gen_frame(HT, 0, 1, 1, 0, -1);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 24'h0, 0, 0, 1'b0);
    @(negedge clk);
    check("frames left unchecked", fq.size(), 0);
    check("pixels left unchecked", pq.size(), 0);
    check("total timing_err lo", err0, 2);
    check("total timing_err hi", err1, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
